// File: rtl/ifetch_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_pkg
// Shared definitions for the instruction-fetch slice.
//   IFETCH_XLEN      default data/PC width
//   IFETCH_RESET_PC  default PC after reset
//   IFETCH_ALIGN     instruction alignment in address bits (word aligned)
//   fetch_entry_t    one fetched instruction {pc, inst} at the default width
// No ports (package).
// -----------------------------------------------------------------------------
package ifetch_pkg;

   localparam int IFETCH_XLEN = 32;
   localparam logic [IFETCH_XLEN-1:0] IFETCH_RESET_PC = 32'h0000_0000;
   localparam int IFETCH_ALIGN = 2;

   typedef struct packed {
      logic [IFETCH_XLEN-1:0] pc;
      logic [IFETCH_XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// -----------------------------------------------------------------------------
// ifetch_fifo
// Circular FIFO with synchronous flush, used as the fetch queue.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset (pointers and count only)
//   i_flush      discard all entries; wins over push/pop in the same cycle
//   i_push       write i_push_data (legal when full only together with i_pop)
//   i_push_data  entry to write
//   i_pop        drop the head entry (ignored when empty)
//   o_head_data  current head entry (combinational read)
//   o_count      number of stored entries, 0..DEPTH
//   o_empty      no entries stored
// -----------------------------------------------------------------------------
module ifetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_data,
   output logic [CNT_W-1:0] o_count,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign o_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));

   // A pop in the same cycle frees the slot, so push-at-full is accepted then.
   assign w_do_push = i_push && (!w_full || i_pop);
   assign w_do_pop  = i_pop && !o_empty;

   // Storage has no reset; only the pointers define which words are live.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head is read combinationally so a word written at an edge is presentable
   // in the very next cycle; the write of a push-at-full lands on the slot the
   // head is leaving, so the presented word is never disturbed.
   assign o_head_data = r_mem[r_rd_ptr];
   assign o_count     = r_count;

endmodule

// File: rtl/ifetch_pipe.sv
// -----------------------------------------------------------------------------
// ifetch_pipe
// Pipelined instruction fetch: issues reads to a 1-cycle-latency instruction
// ROM, buffers {pc, inst} in a fetch queue and offers the queue head to decode
// over valid/ready. A redirect loads a new PC and flushes everything in flight.
// Optional build macro: IFETCH_PERF_EN adds perf_fetched / perf_flushed.
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   redirect_valid  load redirect_pc and flush the pipeline
//   redirect_pc     redirect target (bits [1:0] ignored)
//   imem_req        ROM read enable
//   imem_addr       ROM word address (pc[IADDR_W+1:2])
//   imem_rdata      ROM data, valid the cycle after imem_req
//   out_valid       instruction available at the queue head
//   out_ready       decode accepts the instruction
//   out_inst        instruction word (0 when out_valid=0)
//   out_pc          address of out_inst (0 when out_valid=0)
//   perf_fetched    (IFETCH_PERF_EN) instructions handed to decode
//   perf_flushed    (IFETCH_PERF_EN) queued/in-flight entries discarded
// -----------------------------------------------------------------------------
module ifetch_pipe
   import ifetch_pkg::*;
#(
   parameter int               XLEN     = IFETCH_XLEN,
   parameter int               IADDR_W  = 14,
   parameter logic [XLEN-1:0]  RESET_PC = IFETCH_RESET_PC,
   parameter int               FQ_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [IADDR_W-1:0] imem_addr,
   input  logic [XLEN-1:0]    imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_inst,
   output logic [XLEN-1:0]    out_pc
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_flushed
`endif
);

   localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
   localparam logic [CNT_W:0] C_DEPTH = (CNT_W+1)'(FQ_DEPTH);

   logic [XLEN-1:0]   r_fetch_pc;
   logic [XLEN-1:0]   r_tag;
   logic              r_inflight;

   logic [CNT_W-1:0]  w_count;
   logic              w_empty;
   logic [CNT_W:0]    w_credit_used;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic [2*XLEN-1:0] w_push_data;
   logic [2*XLEN-1:0] w_head_data;
   logic              w_unused;

   // Low target bits are dropped by alignment.
   assign w_unused = &{1'b0, redirect_pc[IFETCH_ALIGN-1:0]};

   // Outstanding requests hold a queue slot, so a response always has room.
   assign w_credit_used = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
   assign w_issue       = !redirect_valid && (w_credit_used < C_DEPTH);

   // A response arriving in a redirect cycle belongs to the old stream.
   assign w_push      = r_inflight && !redirect_valid;
   assign w_push_data = {r_tag, imem_rdata};
   assign w_pop       = out_valid && out_ready;

   // Gating with rst keeps the ROM idle while reset is held, without using
   // rst in any flop's data path.
   assign imem_req  = w_issue && rst;
   assign imem_addr = r_fetch_pc[IADDR_W+1:IFETCH_ALIGN];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_tag      <= '0;
         r_inflight <= 1'b0;
      end else begin
         if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[XLEN-1:IFETCH_ALIGN], {IFETCH_ALIGN{1'b0}}};
         end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(1 << IFETCH_ALIGN);
         end
         if (w_issue) begin
            r_tag <= r_fetch_pc;
         end
         r_inflight <= w_issue;
      end
   end

   ifetch_fifo #(
      .DEPTH (FQ_DEPTH),
      .WIDTH (2*XLEN)
   ) u_fq (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (redirect_valid),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head_data (w_head_data),
      .o_count     (w_count),
      .o_empty     (w_empty)
   );

   assign out_valid = !w_empty;
   assign out_pc    = out_valid ? w_head_data[2*XLEN-1:XLEN] : '0;
   assign out_inst  = out_valid ? w_head_data[XLEN-1:0]      : '0;

`ifdef IFETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_flushed;
   logic [31:0] w_flush_cnt;

   // An entry popped in the redirect cycle was consumed, not discarded.
   assign w_flush_cnt = 32'(w_count) - 32'(w_pop) + 32'(r_inflight);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_fetched <= '0;
         r_perf_flushed <= '0;
      end else begin
         if (w_pop) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         if (redirect_valid) begin
            r_perf_flushed <= r_perf_flushed + w_flush_cnt;
         end
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_ifetch_pipe.sv
`timescale 1ns/1ps
module tb_ifetch_pipe;
   import ifetch_pkg::*;

   localparam int XLEN    = 32;
   localparam int IADDR_W = 14;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               redirect_valid = 1'b0;
   logic [XLEN-1:0]    redirect_pc = '0;
   logic               imem_req;
   logic [IADDR_W-1:0] imem_addr;
   logic [XLEN-1:0]    imem_rdata = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [XLEN-1:0]    out_inst;
   logic [XLEN-1:0]    out_pc;
`ifdef IFETCH_PERF_EN
   logic [31:0]        perf_fetched;
   logic [31:0]        perf_flushed;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;
   int base_pops = 0;

   fetch_entry_t sb_q[$];

   typedef struct {
      logic [31:0]        target;
      logic [IADDR_W-1:0] addr;
      logic [31:0]        pc;
      logic [31:0]        inst;
   } redir_vec_t;
   redir_vec_t vecs [6];

   always #5 clk = ~clk;

   ifetch_pipe dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc)
`ifdef IFETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_flushed   (perf_flushed)
`endif
   );

   function automatic logic [31:0] rom_word(input logic [IADDR_W-1:0] a);
      return 32'(a) + 32'h100;
   endfunction

   // Synchronous ROM: one cycle read latency, holds its last word otherwise.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= rom_word(imem_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard: every handshake must match the oldest expected entry.
   always @(negedge clk) begin
      fetch_entry_t e;
      if (rst && out_valid && out_ready) begin
         n_pops++;
         $display("pop pc=0x%08h inst=0x%08h", out_pc, out_inst);
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc 0x%08h required no instruction", out_pc);
         end else begin
            e = sb_q.pop_front();
            check("pop_pc", out_pc, e.pc);
            check("pop_inst", out_inst, e.inst);
         end
      end
   end

   task automatic expect_stream(input logic [31:0] start, input int n);
      fetch_entry_t e;
      for (int i = 0; i < n; i++) begin
         e.pc   = start + 32'(4 * i);
         e.inst = rom_word(e.pc[IADDR_W+1:2]);
         sb_q.push_back(e);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at cycle 0: the first cycle with rst released.
   task automatic start(input logic ready);
      rst = 1'b0;
      redirect_valid = 1'b0;
      out_ready = ready;
      cyc();
      cyc();
      sb_q.delete();
      rst = 1'b1;
      base_pops = n_pops;
   endtask

   // Called at drive time of cycle R; returns at sample time of R+3.
   task automatic do_redirect(input logic [31:0] target, input logic [IADDR_W-1:0] exp_addr,
                              input logic [31:0] exp_pc, input logic [31:0] exp_inst,
                              input logic [31:0] exp_flushed);
      logic [31:0] fl0;
      fl0 = '0;
      redirect_valid = 1'b1;
      redirect_pc = target;
      $display("redirect to 0x%08h", target);
      #1;
      check("r0_req", 32'(imem_req), 32'd0);
`ifdef IFETCH_PERF_EN
      fl0 = perf_flushed;
`endif
      cyc();
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      sb_q.delete();
      expect_stream(exp_pc, 24);
      #1;
      check("r1_valid", 32'(out_valid), 32'd0);
      check("r1_req", 32'(imem_req), 32'd1);
      check("r1_addr", 32'(imem_addr), 32'(exp_addr));
`ifdef IFETCH_PERF_EN
      check("r1_flushed", perf_flushed - fl0, exp_flushed);
`else
      if (fl0 != exp_flushed) fl0 = exp_flushed;
`endif
      cyc(); #1;
      check("r2_valid", 32'(out_valid), 32'd0);
      cyc(); #1;
      check("r3_valid", 32'(out_valid), 32'd1);
      check("r3_pc", out_pc, exp_pc);
      check("r3_inst", out_inst, exp_inst);
   endtask

   initial begin
      int reqs;
      int found;
      int wait_t;

      vecs[0] = '{32'h0000_0040, 14'h0010, 32'h0000_0040, 32'h0000_0110};
      vecs[1] = '{32'h0000_0043, 14'h0010, 32'h0000_0040, 32'h0000_0110};
      vecs[2] = '{32'h0000_1002, 14'h0400, 32'h0000_1000, 32'h0000_0500};
      vecs[3] = '{32'h0000_FFFE, 14'h3FFF, 32'h0000_FFFC, 32'h0000_40FF};
      vecs[4] = '{32'hFFFF_FFFF, 14'h3FFF, 32'hFFFF_FFFC, 32'h0000_40FF};
      vecs[5] = '{32'h0000_0010, 14'h0004, 32'h0000_0010, 32'h0000_0104};

      // ---- reset values, then streaming from RESET_PC
      out_ready = 1'b1;
      #2;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_inst", out_inst, 32'd0);
      check("rst_pc", out_pc, 32'd0);
`ifdef IFETCH_PERF_EN
      check("rst_perf_fetched", perf_fetched, 32'd0);
      check("rst_perf_flushed", perf_flushed, 32'd0);
`endif
      start(1'b1);
      expect_stream(32'h0, 40);
      #1;
      check("c0_req", 32'(imem_req), 32'd1);
      check("c0_addr", 32'(imem_addr), 32'd0);
      check("c0_valid", 32'(out_valid), 32'd0);
      cyc(); #1;
      check("c1_valid", 32'(out_valid), 32'd0);
      cyc(); #1;
      check("c2_valid", 32'(out_valid), 32'd1);
      check("c2_pc", out_pc, 32'h0);
      check("c2_inst", out_inst, 32'h100);
      for (int i = 0; i < 8; i++) begin
         cyc(); #1;
         check("stream_valid", 32'(out_valid), 32'd1);
      end

      // ---- backpressure: exactly FQ_DEPTH requests, head held stable
      start(1'b0);
      expect_stream(32'h0, 40);
      reqs = 0;
      #1;
      if (imem_req) reqs++;
      for (int k = 1; k < 12; k++) begin
         cyc(); #1;
         if (imem_req) reqs++;
         if (k >= 2) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_pc", out_pc, 32'h0);
            check("hold_inst", out_inst, 32'h100);
         end
      end
      check("bp_req_count", 32'(reqs), 32'd4);
      cyc();
      out_ready = 1'b1;
      #1;
      found = 0;
      wait_t = 0;
      for (int t = 0; t < 8; t++) begin
         if (imem_req) begin
            found = 1;
            wait_t = t;
            break;
         end
         cyc(); #1;
      end
      check("resume_found", 32'(found), 32'd1);
      check("resume_delay", 32'(wait_t), 32'd1);
      check("resume_addr", 32'(imem_addr), 32'd4);
      repeat (8) cyc();

      // ---- redirect while 3 entries are queued and one is in flight
      start(1'b0);
      repeat (4) cyc();
      do_redirect(32'h40, 14'h0010, 32'h40, 32'h110, 32'd4);

      // ---- table of redirect targets while streaming
      for (int i = 0; i < 6; i++) begin
         repeat (6) cyc();
         do_redirect(vecs[i].target, vecs[i].addr, vecs[i].pc, vecs[i].inst, 32'd1);
      end
      repeat (4) cyc();

      // ---- redirect in the same cycle as the handshake of pc 0x8
      start(1'b1);
      expect_stream(32'h0, 40);
      repeat (4) cyc();
      #1;
      check("hs_pc", out_pc, 32'h8);
      check("hs_valid", 32'(out_valid), 32'd1);
      do_redirect(32'h80, 14'h0020, 32'h80, 32'h120, 32'd1);
      check("hs_pops", 32'(n_pops - base_pops), 32'd3);

      // ---- back-to-back redirects: the second one wins
      repeat (3) cyc();
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      $display("redirect to 0x%08h", redirect_pc);
      cyc();
      redirect_pc = 32'h300;
      $display("redirect to 0x%08h", redirect_pc);
      #1;
      check("b2b_r1_req", 32'(imem_req), 32'd0);
      check("b2b_r1_valid", 32'(out_valid), 32'd0);
      cyc();
      redirect_valid = 1'b0;
      sb_q.delete();
      expect_stream(32'h300, 24);
      #1;
      check("b2b_r2_valid", 32'(out_valid), 32'd0);
      check("b2b_r2_addr", 32'(imem_addr), 32'h0C0);
      cyc(); #1;
      check("b2b_r3_valid", 32'(out_valid), 32'd0);
      cyc(); #1;
      check("b2b_r4_valid", 32'(out_valid), 32'd1);
      check("b2b_r4_pc", out_pc, 32'h300);
      check("b2b_r4_inst", out_inst, 32'h1C0);
      repeat (2) cyc();
`ifdef IFETCH_PERF_EN
      #1;
      check("perf_fetched", perf_fetched, 32'(n_pops - base_pops));
`endif

      // ---- reset while the queue is nearly full with a request in flight
      out_ready = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      #1;
      check("mid_rst_req", 32'(imem_req), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_inst", out_inst, 32'd0);
      check("mid_rst_pc", out_pc, 32'd0);
`ifdef IFETCH_PERF_EN
      check("mid_rst_perf_fetched", perf_fetched, 32'd0);
      check("mid_rst_perf_flushed", perf_flushed, 32'd0);
`endif
      start(1'b1);
      expect_stream(32'h0, 20);
      #1;
      check("rr_c0_req", 32'(imem_req), 32'd1);
      check("rr_c0_addr", 32'(imem_addr), 32'd0);
      cyc(); #1;
      check("rr_c1_valid", 32'(out_valid), 32'd0);
      cyc(); #1;
      check("rr_c2_valid", 32'(out_valid), 32'd1);
      check("rr_c2_pc", out_pc, 32'h0);
      check("rr_c2_inst", out_inst, 32'h100);
      repeat (4) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL timeout: got no end of test required end before 100000 ns");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/ifetch_pipe.md
Name: ifetch_pipe

Overview:
- Parametrised, pipelined instruction-fetch unit for the single-issue core.
- Drives a synchronous instruction ROM with 1-cycle read latency and buffers returned words in a small fetch queue.
- Presents {pc, inst} to decode over a valid/ready handshake.
- Accepts a generic redirect (branch/jump target) that flushes in-flight and queued fetches.

Parameters:
- XLEN, 32, data/PC width.
- IADDR_W, 14, ROM word-address width; ROM address = pc[IADDR_W+1:2].
- RESET_PC, 32'h0000_0000, PC value after reset.
- FQ_DEPTH, 4, fetch-queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  load a new PC and flush the pipeline.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0).
- imem_req  out  1  ROM read enable.
- imem_addr  out  IADDR_W  ROM word address.
- imem_rdata  in  XLEN  ROM data, valid the cycle after imem_req.
- out_valid  out  1  fetched instruction available.
- out_ready  in  1  decode accepts the instruction.
- out_inst  out  XLEN  instruction word.
- out_pc  out  XLEN  address of out_inst.

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, queue empty, in-flight flag=0. Outputs: imem_req=0, out_valid=0, out_inst=0, out_pc=0.
- Credit rule: issue when (occupancy + inflight) < FQ_DEPTH and redirect_valid=0. On issue: imem_req=1, imem_addr=fetch_pc[IADDR_W+1:2], tag register <= fetch_pc, fetch_pc <= fetch_pc+4 (wraps modulo 2^XLEN).
- Response: the cycle after an issue, {tag, imem_rdata} is pushed into the queue. The queue can never overflow because in-flight requests are counted against credit.
- Output comes from the queue head only, with no bypass. First out_valid is 2 cycles after the first imem_req. Sustained throughput is 1 instruction/cycle while out_ready=1.
- Handshake:
  - Pop when out_valid && out_ready.
  - out_inst and out_pc must stay stable while out_valid && !out_ready.
  - out_valid never drops without a pop or a redirect.
- Simultaneous push and pop are legal at any occupancy, including full and empty.
- Redirect (cycle R):
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - Queue cleared; the response to any request issued in R-1 is discarded.
  - imem_req=0 in R; target fetched in R+1; out_valid=0 in R+1 and R+2; target instruction presented in R+3.
  - A handshake occurring in cycle R still completes (that instruction counts as consumed).
- Back-to-back redirects: the last one wins, and each one re-flushes.
- Reset asserted mid-operation returns everything to reset values immediately; the in-flight ROM response is ignored after release.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched (32) and perf_flushed (32).
  - perf_fetched increments on each pop.
  - perf_flushed increments by the number of queued plus in-flight entries discarded at each redirect.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package ifetch_pkg: XLEN default, RESET_PC default, instruction-alignment constant (2), and a fetch-entry struct typedef {pc, inst}.
- Sub-module ifetch_fifo (parametrised depth/width circular FIFO with synchronous flush, push, pop, count) instantiated once for the fetch queue.

Test Plan:
- Reset release, out_ready=1, ROM[i]=i+0x100 -> out_valid first high at cycle 2. Then pc 0,4,8,... with inst 0x100,0x101,... one per cycle, no gaps.
- out_ready=0 for 10 cycles after first valid -> imem_req stops after exactly FQ_DEPTH outstanding (4 pushes). out_pc=0/out_inst=0x100 stable. On release, 0,4,8,12 drain, then fetch resumes at 16.
- Redirect to 0x40 while queue holds 3 entries -> those entries are never presented. Next presented out_pc=0x40, inst=ROM[16], exactly 3 cycles after redirect.
- Redirect to 0x43 -> fetch address is 0x40 (imem_addr=16).
- Redirect in the same cycle as a handshake at out_pc=0x8 -> 0x8 is consumed once; 0xC is never presented.
- Reset asserted while the queue is full and a request is in flight -> all outputs 0 immediately. After release, sequence restarts at RESET_PC with no stale instruction. With IFETCH_PERF_EN, counters read 0.
